// File: rtl/mem_requester_if.sv
// Bundles the core request/response channel and the memory controller handshake.
// master is the requester's view; slave is the core-plus-controller side.
interface mem_requester_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          rsp_valid;
    logic          rsp_rw;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic          mem_valid;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_oe;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_err,
        output mem_valid, mem_rw, mem_addr, mem_wdata, mem_oe
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_err,
        input  mem_valid, mem_rw, mem_addr, mem_wdata, mem_oe
    );
endinterface

// File: rtl/mem_requester.sv
// CPU-side initiator: queues core requests and runs one Valid/ready transaction at a time,
// with a timeout and a release phase that waits for ready to drop before the next issue.
module mem_requester #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input logic             i_clk,
    input logic             i_reset,
    mem_requester_if.master bus
);
    localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TmoLastInt = TIMEOUT - 1;
    localparam logic [PW:0]   FullCount = DEPTH[PW:0];
    localparam logic [CW-1:0] TmoLast   = TmoLastInt[CW-1:0];

    typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;

    logic          r_fifo_rw    [DEPTH];
    logic [AW-1:0] r_fifo_addr  [DEPTH];
    logic [DW-1:0] r_fifo_wdata [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    state_e        r_state;
    logic [CW-1:0] r_tmo_cnt;
    logic          r_mem_valid;
    logic          r_mem_rw;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_oe;
    logic          r_rsp_valid;
    logic          r_rsp_rw;
    logic          r_rsp_err;
    logic [DW-1:0] r_rsp_rdata;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FullCount);
    assign w_empty = (r_count == '0);
    // A full FIFO refuses pushes even on a popping edge; ready reflects pre-edge occupancy.
    assign w_push  = bus.req_valid & ~w_full;
    assign w_pop   = (r_state == StIdle) & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rw[r_wr_ptr]    <= bus.req_rw;
            r_fifo_addr[r_wr_ptr]  <= bus.req_addr;
            r_fifo_wdata[r_wr_ptr] <= bus.req_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= StIdle;
            r_tmo_cnt   <= '0;
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rw    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_mem_rw    <= r_fifo_rw[r_rd_ptr];
                        r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                        r_mem_wdata <= r_fifo_wdata[r_rd_ptr];
                        r_mem_oe    <= ~r_fifo_rw[r_rd_ptr];
                        r_mem_valid <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.mem_ready) begin
                        if (r_mem_rw) begin
                            r_rsp_rdata <= bus.mem_rdata;
                        end
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rw    <= r_mem_rw;
                        r_mem_valid <= 1'b0;
                        r_mem_oe    <= 1'b0;
                        r_state     <= StRelease;
                    end else if (r_tmo_cnt == TmoLast) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rw    <= r_mem_rw;
                        r_mem_valid <= 1'b0;
                        r_mem_oe    <= 1'b0;
                        r_state     <= StRelease;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                StRelease: begin
                    // A ready still high from the last transfer must not complete the next one.
                    if (!bus.mem_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = ~w_full;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_oe    = r_mem_oe;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rw    = r_rsp_rw;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_mem_requester.sv
// Randomized scoreboard bench: a controller-plus-RAM model answers the DUT, and expected
// responses are queued at request acceptance and compared when rsp_valid strobes.
module tb_mem_requester;
    localparam int unsigned AW      = 8;
    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned NEVER   = 1000;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [15:0]   delay;
        logic [3:0]    hold;
    } plan_t;

    typedef struct packed {
        logic          rw;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_requester_if #(.AW(AW), .DW(DW)) bus ();

    mem_requester #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus.master)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    plan_t         plan_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] model_ram [256];
    logic [DW-1:0] ctrl_ram  [256];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    endtask

    // Expected outcome is fixed at acceptance: FIFO order plus one outstanding transaction
    // means memory effects happen in push order.
    task automatic push(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int unsigned delay, input int unsigned hold);
        plan_t p;
        exp_t  e;
        int unsigned guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("push_wait_ready", bus.req_ready, 1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        p.rw    = rw;
        p.addr  = addr;
        p.wdata = wdata;
        p.delay = delay[15:0];
        p.hold  = hold[3:0];
        plan_q.push_back(p);
        e.rw    = rw;
        e.err   = (delay >= TIMEOUT);
        e.rdata = rw ? model_ram[addr] : '0;
        if (!rw && !e.err) model_ram[addr] = wdata;
        exp_q.push_back(e);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Controller model: answers each transaction after its planned delay, then optionally
    // keeps ready stuck high for a few cycles.
    initial begin : controller
        plan_t       cur;
        bit          busy     = 1'b0;
        bit          has_plan = 1'b0;
        int unsigned k        = 0;
        int unsigned stuck    = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rdata = $urandom;
            if (bus.mem_valid) begin
                if (stuck > 0) begin
                    check("valid_while_ready_stuck", bus.mem_valid, 0);
                    stuck = 0;
                end
                if (!busy) begin
                    busy     = 1'b1;
                    k        = 0;
                    has_plan = (plan_q.size() > 0);
                    if (has_plan) cur = plan_q.pop_front();
                end
                if (has_plan) begin
                    check("mem_rw", bus.mem_rw, cur.rw);
                    check("mem_addr", bus.mem_addr, cur.addr);
                    check("mem_oe", bus.mem_oe, !cur.rw);
                    if (!cur.rw) check("mem_wdata", bus.mem_wdata, cur.wdata);
                end
                if (has_plan && k == cur.delay && cur.delay < TIMEOUT) begin
                    bus.mem_ready = 1'b1;
                    if (cur.rw) bus.mem_rdata = ctrl_ram[cur.addr];
                    else ctrl_ram[cur.addr] = cur.wdata;
                    stuck = cur.hold;
                end else begin
                    bus.mem_ready = 1'b0;
                end
                k++;
            end else begin
                if (busy && has_plan)
                    check("valid_high_cycles", k,
                          (cur.delay < TIMEOUT) ? cur.delay + 1 : TIMEOUT);
                busy = 1'b0;
                check("mem_oe_when_idle", bus.mem_oe, 0);
                if (stuck > 0) begin
                    bus.mem_ready = 1'b1;
                    stuck--;
                end else begin
                    bus.mem_ready = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", bus.rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rw", bus.rsp_rw, e.rw);
                    check("rsp_err", bus.rsp_err, e.err);
                    if (e.rw && !e.err) check("rsp_rdata", bus.rsp_rdata, e.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned r;
        int unsigned dly;
        int unsigned hold;
        for (int i = 0; i < 256; i++) begin
            model_ram[i] = '0;
            ctrl_ram[i]  = '0;
        end
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst_n         = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_mem_rw", bus.mem_rw, 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_oe", bus.mem_oe, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_req_ready", bus.req_ready, 1);
        rst_n = 1'b1;

        // Reset mid-ISSUE with a second request still queued; neither may produce a response.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 8'h33;
        bus.req_wdata = 32'h1234_5678;
        @(negedge clk);
        bus.req_addr  = 8'h34;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.mem_valid; i++) @(negedge clk);
        check("pre_reset_issue", bus.mem_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_drops_valid", bus.mem_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_valid_low", bus.mem_valid, 0);
        check("reset_req_ready", bus.req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fifo_empty_after_reset", bus.mem_valid, 0);
        end

        push(1'b0, 8'hAA, 32'h000A_FFFA, 3, 0);
        drain();

        push(1'b0, 8'hAA, 32'h000A_FFFA, 1, 0);
        push(1'b0, 8'hCC, 32'h0000_0CFA, 2, 0);
        push(1'b1, 8'hAA, 32'h0, 0, 0);
        push(1'b1, 8'hCC, 32'h0, 4, 0);
        drain();

        // Fill: one in flight plus DEPTH queued; an extra push while full must be dropped.
        push(1'b1, 8'hAA, 32'h0, 8, 0);
        push(1'b1, 8'hCC, 32'h0, 0, 0);
        push(1'b0, 8'h10, 32'hDEAD_BEEF, 0, 0);
        @(negedge clk);
        check("full_req_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 8'h55;
        bus.req_wdata = 32'h5555_5555;
        repeat (3) @(negedge clk);
        check("full_req_ready_held", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("no_extra_after_full", bus.mem_valid, 0);

        push(1'b1, 8'h20, 32'h0, NEVER, 0);
        push(1'b0, 8'h21, 32'hCAFE_0021, 1, 0);
        push(1'b0, 8'h22, 32'h0BAD_0022, NEVER, 0);
        push(1'b1, 8'hAA, 32'h0, TIMEOUT - 1, 0);
        drain();

        push(1'b0, 8'h30, 32'h3030_3030, 2, 4);
        push(1'b1, 8'h30, 32'h0, 0, 0);
        drain();

        for (int i = 0; i < 150; i++) begin
            r    = $urandom_range(0, 19);
            dly  = (r == 0) ? NEVER : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, dly, hold);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
